uart_tx: RTL and testbench

- UART transmitter: the counterpart of the team's uart_rx.
- Accepts bytes over a valid/ready handshake into a small internal FIFO and serialises them onto tx_pin.
- Frame format: LSB first, 1 start bit, 8 data bits, optional parity bit, 1 stop bit.
- Bit timing matches uart_rx so the two blocks can be looped back directly; sits on the logic analyzer's host-bound path.

---
 rtl/uart_tx.sv | 187 ++++++++++++++++++
 tb/tb_uart_tx.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter: bytes enter a small FIFO over a valid/ready handshake and leave
// LSB first on tx_pin as start, 8 data bits, optional parity and one stop bit.
module uart_tx #(
  parameter int BAUD_PRESCALER = 5,
  parameter int FIFO_DEPTH     = 4,
  parameter int PARITY         = 0
) (
  input  logic                          i_clk,
  input  logic                          _rst,
  input  logic [7:0]                    i_data,
  input  logic                          i_valid,
  output logic                          o_ready,
  output logic                          tx_pin,
  output logic                          o_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = $clog2(BAUD_PRESCALER + 1);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_PRESCALER);
  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [CNT_W-1:0]   r_baud;
  logic [CNT_W-1:0]   w_baud_next;
  logic [2:0]         r_bit_idx;
  logic [2:0]         w_bit_idx_next;
  logic [7:0]         r_shift;
  logic [7:0]         w_shift_next;
  logic               r_par;
  logic               w_par_next;
  logic               r_tx;
  logic               w_tx_next;

  logic [7:0]         r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [LVL_W-1:0]   r_count;

  logic               w_push;
  logic               w_pop;
  logic               w_load;
  logic               w_baud_wrap;
  logic [7:0]         w_head;

  function automatic logic parity_of(input logic [7:0] d);
    return (PARITY == 2) ? ~^d : ^d;
  endfunction

  assign o_ready     = (r_count != LVL_FULL);
  assign o_busy      = (r_state != S_IDLE) || (r_count != '0);
  assign o_level     = r_count;
  assign tx_pin      = r_tx;
  assign w_push      = i_valid && o_ready;
  assign w_head      = r_mem[r_rd_ptr];
  assign w_baud_wrap = (r_baud == BAUD_LAST);

  always_ff @(posedge i_clk or negedge _rst) begin
    if (!_rst) begin
      r_state   <= S_IDLE;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_par     <= 1'b0;
      r_tx      <= 1'b1;
    end else begin
      r_state   <= w_state_next;
      r_baud    <= w_baud_next;
      r_bit_idx <= w_bit_idx_next;
      r_shift   <= w_shift_next;
      r_par     <= w_par_next;
      r_tx      <= w_tx_next;
    end
  end

  // tx is registered, so every transition loads the line value of the state being entered.
  always_comb begin
    w_state_next   = r_state;
    w_baud_next    = r_baud;
    w_bit_idx_next = r_bit_idx;
    w_shift_next   = r_shift;
    w_par_next     = r_par;
    w_tx_next      = r_tx;
    w_load         = 1'b0;

    if (r_state != S_IDLE) begin
      w_baud_next = w_baud_wrap ? '0 : r_baud + 1'b1;
    end

    case (r_state)
      S_IDLE: begin
        w_tx_next = 1'b1;
        w_load    = (r_count != '0);
      end
      S_START: begin
        if (w_baud_wrap) begin
          w_state_next   = S_DATA;
          w_bit_idx_next = 3'd0;
          w_tx_next      = r_shift[0];
          w_shift_next   = {1'b0, r_shift[7:1]};
        end
      end
      S_DATA: begin
        if (w_baud_wrap) begin
          if (r_bit_idx == 3'd7) begin
            if (PARITY != 0) begin
              w_state_next = S_PAR;
              w_tx_next    = r_par;
            end else begin
              w_state_next = S_STOP;
              w_tx_next    = 1'b1;
            end
          end else begin
            w_bit_idx_next = r_bit_idx + 3'd1;
            w_tx_next      = r_shift[0];
            w_shift_next   = {1'b0, r_shift[7:1]};
          end
        end
      end
      S_PAR: begin
        if (w_baud_wrap) begin
          w_state_next = S_STOP;
          w_tx_next    = 1'b1;
        end
      end
      S_STOP: begin
        if (w_baud_wrap) begin
          w_state_next = S_IDLE;
          w_tx_next    = 1'b1;
          w_load       = (r_count != '0);
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_tx_next    = 1'b1;
      end
    endcase

    // Starting a frame from IDLE or straight out of STOP leaves no idle gap.
    if (w_load) begin
      w_state_next = S_START;
      w_baud_next  = '0;
      w_shift_next = w_head;
      w_par_next   = parity_of(w_head);
      w_tx_next    = 1'b0;
    end
  end

  assign w_pop = w_load;

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk or negedge _rst) begin
    if (!_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three instances (no, even, odd parity) share clock and reset;
// a per-instance line monitor decodes frames against a scoreboard queue.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din  [3];
  logic       vin  [3];
  logic       rdy  [3];
  logic       tx   [3];
  logic       bsy  [3];
  logic [2:0] lvl  [3];
  logic       chk_gap [3];

  typedef struct {
    logic [7:0] data;
    logic       par;
  } exp_t;

  typedef struct {
    int         sel;
    logic [7:0] data;
    logic       par;
  } vec_t;

  exp_t sb_q [3][$];
  int   checks = 0;
  int   errors = 0;

  always #2 clk = ~clk;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      localparam int NBITS = (gi == 0) ? 10 : 11;

      uart_tx #(
        .BAUD_PRESCALER(5),
        .FIFO_DEPTH    (4),
        .PARITY        (gi)
      ) u_dut (
        .i_clk  (clk),
        ._rst   (rst_n),
        .i_data (din[gi]),
        .i_valid(vin[gi]),
        .o_ready(rdy[gi]),
        .tx_pin (tx[gi]),
        .o_busy (bsy[gi]),
        .o_level(lvl[gi])
      );

      // Line monitor: samples mid-bit (3 clocks into each 6-clock bit), acting as receiver.
      initial begin : mon
        logic [10:0] bits;
        logic [10:0] ef;
        bit          aborted;
        bit          have_prev;
        int          idle;
        exp_t        e;
        have_prev = 0;
        idle      = 0;
        forever begin
          @(negedge clk);
          if (!rst_n || tx[gi]) begin
            idle++;
            continue;
          end
          bits    = '0;
          aborted = 0;
          for (int c = 1; c <= 6 * NBITS - 1; c++) begin
            @(negedge clk);
            if (!rst_n) begin
              aborted = 1;
              break;
            end
            if (c % 6 == 3) bits[c / 6] = tx[gi];
          end
          if (!aborted) begin
            if (chk_gap[gi] && have_prev) begin
              checks++;
              if (idle != 0) begin
                errors++;
                $display("FAIL gap dut%0d: idle cycles %0d, required 0", gi, idle);
              end
            end
            checks++;
            if (sb_q[gi].size() == 0) begin
              errors++;
              $display("FAIL unexpected_frame dut%0d: got bits %b, required no frame", gi, bits);
            end else begin
              e  = sb_q[gi].pop_front();
              ef = '0;
              ef[8:1] = e.data;
              if (NBITS == 11) begin
                ef[9]  = e.par;
                ef[10] = 1'b1;
              end else begin
                ef[9] = 1'b1;
              end
              if (bits != ef) begin
                errors++;
                $display("FAIL frame dut%0d: got bits %b, required %b", gi, bits, ef);
              end else begin
                $display("dut%0d frame data=%02h bits=%b gap=%0d", gi, e.data, bits, idle);
              end
            end
            have_prev = chk_gap[gi];
          end else begin
            have_prev = 0;
          end
          idle = 0;
        end
      end
    end
  endgenerate

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  task automatic send_one(input int sel, input logic [7:0] d, input logic p);
    int   nb;
    int   hi;
    exp_t e;
    nb = (sel == 0) ? 10 : 11;
    @(negedge clk);
    din[sel] = d;
    vin[sel] = 1'b1;
    e.data   = d;
    e.par    = p;
    sb_q[sel].push_back(e);
    @(negedge clk);
    vin[sel] = 1'b0;
    check($sformatf("push_state dut%0d %02h", sel, d), {tx[sel], bsy[sel], lvl[sel]}, 5'b11_001);
    @(negedge clk);
    check($sformatf("tx_fall dut%0d %02h", sel, d), {tx[sel], lvl[sel]}, 4'b0_000);
    hi = 2;
    @(negedge clk);
    while (bsy[sel] && hi < 200) begin
      hi++;
      @(negedge clk);
    end
    check($sformatf("busy_len dut%0d %02h", sel, d), hi, 6 * nb + 1);
    check($sformatf("sb_empty dut%0d %02h", sel, d), sb_q[sel].size(), 0);
  endtask

  localparam int NV = 9;
  vec_t vecs [NV];

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int   idx;
    int   cyc;
    int   maxl;
    int   bad_rdy;
    bit   saw_full;
    exp_t e;

    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      vin[d]     = 1'b0;
      din[d]     = 8'h00;
      chk_gap[d] = 1'b0;
    end

    vecs[0] = '{0, 8'h5A, 1'b0};
    vecs[1] = '{1, 8'h5A, 1'b0};
    vecs[2] = '{2, 8'h5A, 1'b1};
    vecs[3] = '{1, 8'h07, 1'b1};
    vecs[4] = '{2, 8'h07, 1'b0};
    vecs[5] = '{0, 8'h6D, 1'b0};
    vecs[6] = '{0, 8'hB4, 1'b0};
    vecs[7] = '{1, 8'h6D, 1'b1};
    vecs[8] = '{2, 8'hB4, 1'b1};

    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        vin[d] = k[0];
        din[d] = 8'($urandom);
      end
      #1;
      for (int d = 0; d < 3; d++) begin
        check($sformatf("reset dut%0d cyc%0d", d, k), {tx[d], rdy[d], bsy[d], lvl[d]}, 6'b110_000);
      end
    end
    @(negedge clk);
    for (int d = 0; d < 3; d++) vin[d] = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < NV; v++) begin
      send_one(vecs[v].sel, vecs[v].data, vecs[v].par);
    end

    // Back-to-back with valid held: 0x01..0x06 into a 4-deep FIFO.
    chk_gap[0] = 1'b1;
    idx = 0; cyc = 0; maxl = 0; bad_rdy = 0; saw_full = 0;
    @(negedge clk);
    while (!(idx == 6 && !bsy[0]) && cyc < 1000) begin
      cyc++;
      if (int'(lvl[0]) > maxl) maxl = int'(lvl[0]);
      if (rdy[0] != (lvl[0] != 3'd4)) bad_rdy++;
      if (lvl[0] == 3'd4 && !rdy[0]) saw_full = 1;
      if (idx < 6) begin
        din[0] = 8'(idx + 1);
        vin[0] = 1'b1;
        if (rdy[0]) begin
          e.data = 8'(idx + 1);
          e.par  = 1'b0;
          sb_q[0].push_back(e);
          idx++;
        end
      end else begin
        vin[0] = 1'b0;
      end
      @(negedge clk);
    end
    vin[0]     = 1'b0;
    chk_gap[0] = 1'b0;
    check("b2b_done", {idx[3:0], bsy[0]}, 5'b0110_0);
    check("b2b_level_peak", maxl, 4);
    check("b2b_ready_vs_level", bad_rdy, 0);
    check("b2b_saw_full", saw_full, 1);
    check("b2b_sb_empty", sb_q[0].size(), 0);

    // Reset during data bit 3 of 0xA5 with two more bytes queued.
    @(negedge clk);
    din[0] = 8'hA5;
    vin[0] = 1'b1;
    @(negedge clk);
    din[0] = 8'h11;
    @(negedge clk);
    din[0] = 8'h22;
    @(negedge clk);
    vin[0] = 1'b0;
    repeat (25) @(negedge clk);
    check("midframe_bit3", tx[0], 1'b0);
    rst_n = 1'b0;
    #1;
    check("midframe_reset_now", {tx[0], rdy[0], bsy[0], lvl[0]}, 6'b110_000);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("after_reset_level", lvl[0], 3'd0);
    send_one(0, 8'h3C, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
